// File: rtl/exe_cmd_issuer.sv
// Command issuer for exe_unit_w1: buffers commands in a FIFO, issues one per clock,
// and captures the unit's result/status after a fixed latency.
module exe_cmd_issuer #(
    parameter int m     = 4,
    parameter int n     = 2,
    parameter int DEPTH = 4,
    parameter int LAT   = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rsn,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [n-1:0]             i_oper,
    input  logic [m-1:0]             i_argA,
    input  logic [m-1:0]             i_argB,
    input  logic                     i_hold,
    input  logic                     i_flush,
    output logic [n-1:0]             o_oper,
    output logic [m-1:0]             o_argA,
    output logic [m-1:0]             o_argB,
    output logic                     o_issue,
    input  logic [m-1:0]             i_result,
    input  logic [3:0]               i_status,
    output logic                     o_res_valid,
    output logic [m-1:0]             o_result,
    output logic [3:0]               o_status,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = n + 2 * m;

    logic [EW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LAT-1:0] in_flight;
    logic           push;
    logic           pop;

    // Held low during reset so upstream never sees a ready it cannot use.
    assign o_ready = i_rsn && (o_count != CW'(DEPTH));
    assign push    = i_valid && o_ready && !i_flush;
    assign pop     = (o_count != '0) && !i_hold && !i_flush;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_oper, i_argA, i_argB};
        end
    end

    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_count     <= '0;
            o_oper      <= '0;
            o_argA      <= '0;
            o_argB      <= '0;
            o_issue     <= 1'b0;
            in_flight   <= '0;
            o_res_valid <= 1'b0;
            o_result    <= '0;
            o_status    <= '0;
        end else if (i_flush) begin
            // Operand and result registers deliberately keep their last values.
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_count     <= '0;
            o_issue     <= 1'b0;
            in_flight   <= '0;
            o_res_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr                   <= rd_ptr + AW'(1);
                {o_oper, o_argA, o_argB} <= mem[rd_ptr];
            end
            o_issue <= pop;

            case ({push, pop})
                2'b10:   o_count <= o_count + CW'(1);
                2'b01:   o_count <= o_count - CW'(1);
                default: o_count <= o_count;
            endcase

            in_flight[0] <= o_issue;
            for (int i = 1; i < LAT; i++) begin
                in_flight[i] <= in_flight[i-1];
            end

            if (in_flight[LAT-1]) begin
                o_res_valid <= 1'b1;
                o_result    <= i_result;
                o_status    <= i_status;
            end else begin
                o_res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exe_cmd_issuer.sv
// Directed bench for exe_cmd_issuer with a one-cycle exe_unit stub
// (result = argA ^ argB, status = 4'b0101).
module tb_exe_cmd_issuer;

    logic       clk = 1'b0;
    logic       rsn;
    logic       valid;
    logic       ready;
    logic [1:0] oper;
    logic [3:0] arg_a;
    logic [3:0] arg_b;
    logic       hold;
    logic       flush;
    logic [1:0] x_oper;
    logic [3:0] x_arg_a;
    logic [3:0] x_arg_b;
    logic       issue;
    logic [3:0] stub_result;
    logic [3:0] stub_status;
    logic       res_valid;
    logic [3:0] result;
    logic [3:0] status;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;
    logic [3:0] iss_q[$];
    logic [3:0] res_q[$];

    exe_cmd_issuer #(.m(4), .n(2), .DEPTH(4), .LAT(1)) dut (
        .i_clk       (clk),
        .i_rsn       (rsn),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_oper      (oper),
        .i_argA      (arg_a),
        .i_argB      (arg_b),
        .i_hold      (hold),
        .i_flush     (flush),
        .o_oper      (x_oper),
        .o_argA      (x_arg_a),
        .o_argB      (x_arg_b),
        .o_issue     (issue),
        .i_result    (stub_result),
        .i_status    (stub_status),
        .o_res_valid (res_valid),
        .o_result    (result),
        .o_status    (status),
        .o_count     (count)
    );

    always #5 clk = ~clk;

    // Single-register exe unit stub: result valid one edge after operands.
    always_ff @(posedge clk) begin
        stub_result <= x_arg_a ^ x_arg_b;
        stub_status <= 4'b0101;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (issue) iss_q.push_back(x_arg_a);
        if (res_valid) res_q.push_back(result);
    endtask

    task automatic test_reset();
        rsn   = 1'b0;
        valid = 1'($urandom);
        oper  = 2'($urandom);
        arg_a = 4'($urandom);
        arg_b = 4'($urandom);
        hold  = 1'($urandom);
        flush = 1'($urandom);
        tick();
        tick();
        checks++;
        if ({issue, res_valid, ready, count, x_oper, x_arg_a, x_arg_b, result, status} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got is=%b rv=%b rdy=%b cnt=%0d op=%h a=%h b=%h r=%h s=%h exp all 0",
                     issue, res_valid, ready, count, x_oper, x_arg_a, x_arg_b, result, status);
        end
        valid = 1'b0; hold = 1'b0; flush = 1'b0;
        rsn   = 1'b1;
        tick();
        checks++;
        if (ready !== 1'b1 || count !== 3'd0 || issue !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b cnt=%0d is=%b exp 1 0 0", ready, count, issue);
        end
    endtask

    task automatic test_single();
        valid = 1'b1; oper = 2'b11; arg_a = 4'b1000; arg_b = 4'b0001;
        tick();
        valid = 1'b0;
        checks++;
        if (count !== 3'd1 || issue !== 1'b0) begin
            errors++;
            $display("FAIL single_push: got cnt=%0d is=%b exp 1 0", count, issue);
        end
        tick();
        checks++;
        if (issue !== 1'b1 || x_oper !== 2'b11 || x_arg_a !== 4'b1000 || x_arg_b !== 4'b0001) begin
            errors++;
            $display("FAIL single_issue: got is=%b op=%b a=%b b=%b exp 1 11 1000 0001",
                     issue, x_oper, x_arg_a, x_arg_b);
        end
        tick();
        checks++;
        if (issue !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_gap: got is=%b rv=%b exp 0 0", issue, res_valid);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || result !== 4'b1001 || status !== 4'b0101) begin
            errors++;
            $display("FAIL single_result: got rv=%b r=%b s=%b exp 1 1001 0101", res_valid, result, status);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0 || result !== 4'b1001 || x_arg_a !== 4'b1000) begin
            errors++;
            $display("FAIL single_hold_value: got rv=%b r=%b a=%b exp 0 1001 1000", res_valid, result, x_arg_a);
        end
    endtask

    task automatic test_fill();
        logic [3:0] seq [5];
        seq[0] = 4'b1001; seq[1] = 4'b0111; seq[2] = 4'b0110; seq[3] = 4'b0101; seq[4] = 4'b0011;
        iss_q.delete(); res_q.delete();
        hold = 1'b1; valid = 1'b1; oper = 2'b01; arg_b = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            arg_a = seq[i];
            tick();
        end
        checks++;
        if (count !== 3'd4 || ready !== 1'b0 || issue !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got cnt=%0d rdy=%b is=%b exp 4 0 0", count, ready, issue);
        end
        valid = 1'b0; hold = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (iss_q.size() != 4 || res_q.size() != 4 || count !== 3'd0) begin
            errors++;
            $display("FAIL fill_drain: got issues=%0d results=%0d cnt=%0d exp 4 4 0",
                     iss_q.size(), res_q.size(), count);
        end
        for (int i = 0; i < 4 && i < iss_q.size(); i++) begin
            checks++;
            if (iss_q[i] !== seq[i]) begin
                errors++;
                $display("FAIL fill_order[%0d]: got %b exp %b", i, iss_q[i], seq[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        iss_q.delete(); res_q.delete();
        hold = 1'b1; valid = 1'b1; oper = 2'b10; arg_b = 4'b0011;
        arg_a = 4'd1; tick();
        arg_a = 4'd2; tick();
        hold = 1'b0;
        for (int k = 3; k <= 8; k++) begin
            arg_a = 4'(k);
            tick();
            checks++;
            if (count !== 3'd2 || issue !== 1'b1) begin
                errors++;
                $display("FAIL b2b_steady[%0d]: got cnt=%0d is=%b exp 2 1", k, count, issue);
            end
        end
        valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (iss_q.size() != 8 || res_q.size() != 8 || count !== 3'd0) begin
            errors++;
            $display("FAIL b2b_totals: got issues=%0d results=%0d cnt=%0d exp 8 8 0",
                     iss_q.size(), res_q.size(), count);
        end
        for (int i = 0; i < 8 && i < iss_q.size() && i < res_q.size(); i++) begin
            checks++;
            if (iss_q[i] !== 4'(i + 1) || res_q[i] !== (4'(i + 1) ^ 4'b0011)) begin
                errors++;
                $display("FAIL b2b_order[%0d]: got a=%h r=%h exp a=%h r=%h",
                         i, iss_q[i], res_q[i], 4'(i + 1), 4'(i + 1) ^ 4'b0011);
            end
        end
    endtask

    task automatic test_flush();
        logic [3:0] fl_a [4];
        fl_a[0] = 4'hA; fl_a[1] = 4'h6; fl_a[2] = 4'h7; fl_a[3] = 4'hE;
        iss_q.delete(); res_q.delete();
        hold = 1'b1; valid = 1'b1; oper = 2'b00; arg_b = 4'h1;
        for (int i = 0; i < 4; i++) begin
            arg_a = fl_a[i];
            tick();
        end
        valid = 1'b0; hold = 1'b0;
        tick();
        checks++;
        if (issue !== 1'b1 || x_arg_a !== 4'hA || count !== 3'd3) begin
            errors++;
            $display("FAIL flush_setup: got is=%b a=%h cnt=%0d exp 1 a 3", issue, x_arg_a, count);
        end
        hold = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; hold = 1'b0;
        checks++;
        if (count !== 3'd0 || ready !== 1'b1 || issue !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: got cnt=%0d rdy=%b is=%b rv=%b exp 0 1 0 0", count, ready, issue, res_valid);
        end
        checks++;
        if (x_arg_a !== 4'hA || x_arg_b !== 4'h1 || result !== 4'hB || status !== 4'b0101) begin
            errors++;
            $display("FAIL flush_keep: got a=%h b=%h r=%h s=%b exp a 1 b 0101", x_arg_a, x_arg_b, result, status);
        end
        iss_q.delete(); res_q.delete();
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (iss_q.size() != 0 || res_q.size() != 0) begin
            errors++;
            $display("FAIL flush_quiet: got issues=%0d results=%0d exp 0 0", iss_q.size(), res_q.size());
        end
    endtask

    task automatic test_async_reset();
        res_q.delete();
        valid = 1'b1; oper = 2'b01; arg_a = 4'hC; arg_b = 4'h3;
        tick();
        valid = 1'b0;
        tick();
        tick();
        #2;
        rsn = 1'b0;
        #1;
        checks++;
        if ({issue, res_valid, ready, count, x_oper, x_arg_a, x_arg_b, result, status} !== '0) begin
            errors++;
            $display("FAIL async_reset: got is=%b rv=%b rdy=%b cnt=%0d op=%h a=%h b=%h r=%h s=%h exp all 0",
                     issue, res_valid, ready, count, x_oper, x_arg_a, x_arg_b, result, status);
        end
        #2;
        rsn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (res_q.size() != 0 || result !== 4'h0) begin
            errors++;
            $display("FAIL async_no_result: got results=%0d r=%h exp 0 0", res_q.size(), result);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
